// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI SRAM responder: response codes, widths,
// read/write FSM state encodings and the word range check.
package axi_sram_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_BEAT = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  // True when the word addressed by a byte address lies beyond the RAM.
  function automatic logic word_oor(input logic [31:0] addr, input int unsigned words);
    return {2'b00, addr[31:2]} >= words;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Byte-strobe word RAM: one write port, one registered read port.
// A read and a write to the same word at the same edge return the old word.
module axi_sram_mem
  import axi_sram_pkg::*;
#(
  parameter int unsigned WORDS = 16384,
  parameter int unsigned AW    = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Byte-enabled write; contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read, sampled only when a beat is loaded so the output holds
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI responder backed by on-chip word RAM. INCR bursts only, 32-bit data,
// IDs echoed, OKAY or SLVERR (beat beyond MEM_WORDS, or wlast/awlen mismatch).
// Optional build macro AXI_SLV_STALL_EN: backpressure one cycle in four.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned R_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic w_stall;

  // Read channel state
  rd_state_e       r_rd_state, w_rd_state_d;
  logic [7:0]      r_rd_wait, w_rd_wait_d;
  logic [31:0]     r_rd_addr, w_rd_addr_d;
  logic [7:0]      r_rd_len, w_rd_len_d;
  logic [2:0]      r_rd_size, w_rd_size_d;
  logic [7:0]      r_rd_beat, w_rd_beat_d;
  logic [ID_W-1:0] r_rid, w_rid_d;
  logic            r_rvalid, w_rvalid_d;
  logic            r_rlast, w_rlast_d;
  logic [1:0]      r_rresp, w_rresp_d;
  logic            w_rd_load;
  logic [31:0]     w_rd_incr;

  // Write channel state
  wr_state_e       r_wr_state, w_wr_state_d;
  logic [31:0]     r_wr_addr, w_wr_addr_d;
  logic [7:0]      r_wr_len, w_wr_len_d;
  logic [2:0]      r_wr_size, w_wr_size_d;
  logic [7:0]      r_wr_beat, w_wr_beat_d;
  logic            r_wr_err, w_wr_err_d;
  logic [ID_W-1:0] r_bid, w_bid_d;
  logic            r_bvalid, w_bvalid_d;
  logic [1:0]      r_bresp, w_bresp_d;
  logic            w_wready;
  logic            w_wr_final;
  logic            w_wr_oor;
  logic            w_mem_we;
  logic [31:0]     w_wr_incr;

  logic [DATA_W-1:0] w_mem_rdata;

`ifdef AXI_SLV_STALL_EN
  logic [1:0] r_stall_cnt;

  // Free-running pacing counter; the all-ones count is a backpressure cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 2'd1;
    end
  end

  assign w_stall = &r_stall_cnt;
`else
  assign w_stall = 1'b0;
`endif

  assign w_rd_incr  = 32'd1 << r_rd_size;
  assign w_wr_incr  = 32'd1 << r_wr_size;
  assign w_wready   = (r_wr_state == WR_DATA) && !w_stall;
  assign w_wr_final = (r_wr_beat == r_wr_len);
  assign w_wr_oor   = word_oor(r_wr_addr, MEM_WORDS);

  // Read next-state: AR capture, latency wait, beat sequencing
  always_comb begin
    w_rd_state_d = r_rd_state;
    w_rd_wait_d  = r_rd_wait;
    w_rd_addr_d  = r_rd_addr;
    w_rd_len_d   = r_rd_len;
    w_rd_size_d  = r_rd_size;
    w_rd_beat_d  = r_rd_beat;
    w_rid_d      = r_rid;
    w_rvalid_d   = r_rvalid;
    w_rlast_d    = r_rlast;
    w_rresp_d    = r_rresp;
    w_rd_load    = 1'b0;
    unique case (r_rd_state)
      RD_IDLE: begin
        if (arvalid) begin
          w_rid_d     = arid;
          w_rd_addr_d = araddr;
          w_rd_len_d  = arlen;
          w_rd_size_d = arsize;
          w_rd_beat_d = 8'd0;
          if (R_LATENCY == 0) begin
            w_rd_state_d = RD_BEAT;
            w_rd_load    = !w_stall;
          end else begin
            w_rd_state_d = RD_WAIT;
            w_rd_wait_d  = 8'(R_LATENCY - 1);
          end
        end
      end
      RD_WAIT: begin
        if (r_rd_wait == 8'd0) begin
          w_rd_state_d = RD_BEAT;
          w_rd_load    = !w_stall;
        end else begin
          w_rd_wait_d = r_rd_wait - 8'd1;
        end
      end
      RD_BEAT: begin
        // rvalid low in RD_BEAT means a beat is pending behind a stall cycle
        if (!r_rvalid) begin
          w_rd_load = !w_stall;
        end else if (rready) begin
          if (r_rlast) begin
            w_rd_state_d = RD_IDLE;
            w_rvalid_d   = 1'b0;
            w_rlast_d    = 1'b0;
          end else begin
            w_rd_addr_d = r_rd_addr + w_rd_incr;
            w_rd_beat_d = r_rd_beat + 8'd1;
            w_rvalid_d  = 1'b0;
            w_rd_load   = !w_stall;
          end
        end
      end
      default: w_rd_state_d = RD_IDLE;
    endcase
    if (w_rd_load) begin
      w_rvalid_d = 1'b1;
      w_rlast_d  = (w_rd_beat_d == w_rd_len_d);
      w_rresp_d  = word_oor(w_rd_addr_d, MEM_WORDS) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= RD_IDLE;
      r_rd_wait  <= '0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_size  <= '0;
      r_rd_beat  <= '0;
      r_rid      <= '0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_d;
      r_rd_wait  <= w_rd_wait_d;
      r_rd_addr  <= w_rd_addr_d;
      r_rd_len   <= w_rd_len_d;
      r_rd_size  <= w_rd_size_d;
      r_rd_beat  <= w_rd_beat_d;
      r_rid      <= w_rid_d;
      r_rvalid   <= w_rvalid_d;
      r_rlast    <= w_rlast_d;
      r_rresp    <= w_rresp_d;
    end
  end

  // Write next-state: AW capture, beat writes, sticky error, B response
  always_comb begin
    w_wr_state_d = r_wr_state;
    w_wr_addr_d  = r_wr_addr;
    w_wr_len_d   = r_wr_len;
    w_wr_size_d  = r_wr_size;
    w_wr_beat_d  = r_wr_beat;
    w_wr_err_d   = r_wr_err;
    w_bid_d      = r_bid;
    w_bvalid_d   = r_bvalid;
    w_bresp_d    = r_bresp;
    w_mem_we     = 1'b0;
    unique case (r_wr_state)
      WR_IDLE: begin
        if (awvalid) begin
          w_bid_d      = awid;
          w_wr_addr_d  = awaddr;
          w_wr_len_d   = awlen;
          w_wr_size_d  = awsize;
          w_wr_beat_d  = 8'd0;
          w_wr_err_d   = 1'b0;
          w_wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (wvalid && w_wready) begin
          w_mem_we    = !w_wr_oor;
          w_wr_err_d  = r_wr_err | w_wr_oor | (wlast != w_wr_final);
          w_wr_addr_d = r_wr_addr + w_wr_incr;
          w_wr_beat_d = r_wr_beat + 8'd1;
          if (wlast || w_wr_final) begin
            w_wr_state_d = WR_RESP;
            w_bvalid_d   = 1'b1;
            w_bresp_d    = w_wr_err_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      WR_RESP: begin
        if (bready) begin
          w_wr_state_d = WR_IDLE;
          w_bvalid_d   = 1'b0;
        end
      end
      default: w_wr_state_d = WR_IDLE;
    endcase
  end

  // Write state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= WR_IDLE;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_size  <= '0;
      r_wr_beat  <= '0;
      r_wr_err   <= 1'b0;
      r_bid      <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_d;
      r_wr_addr  <= w_wr_addr_d;
      r_wr_len   <= w_wr_len_d;
      r_wr_size  <= w_wr_size_d;
      r_wr_beat  <= w_wr_beat_d;
      r_wr_err   <= w_wr_err_d;
      r_bid      <= w_bid_d;
      r_bvalid   <= w_bvalid_d;
      r_bresp    <= w_bresp_d;
    end
  end

  axi_sram_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_addr[AW+1:2]),
    .i_wdata (wdata),
    .i_wstrb (wstrb),
    .i_re    (w_rd_load),
    .i_raddr (w_rd_addr_d[AW+1:2]),
    .o_rdata (w_mem_rdata)
  );

  assign arready = (r_rd_state == RD_IDLE);
  assign rid     = r_rid;
  assign rdata   = (r_rresp == RESP_SLVERR) ? '0 : w_mem_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rvalid  = r_rvalid;
  assign awready = (r_wr_state == WR_IDLE);
  assign wready  = w_wready;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus random
// bursts checked against a word-array model of the RAM.
module tb_axi_sram_slave;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned R_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] w_data_q [$];
  logic [3:0]  w_strb_q [$];

  always #5 clk = ~clk;

  axi_sram_slave #(
    .MEM_WORDS (MEM_WORDS),
    .R_LATENCY (R_LATENCY)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(MEM_WORDS);
  endfunction

  // Read burst; expectations are snapshotted from the model before any time passes
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int stall_beat, input int stall_cycles,
                          output logic [31:0] first_data);
    logic [31:0] e_data [256];
    logic [1:0]  e_resp [256];
    logic [31:0] a;
    int          t;
    first_data = '0;
    for (int k = 0; k <= int'(len); k++) begin
      a = addr + 32'(k) * (32'd1 << size);
      if (in_range(a)) begin
        e_data[k] = m_mem[int'(a[31:2])];
        e_resp[k] = 2'b00;
      end else begin
        e_data[k] = 32'd0;
        e_resp[k] = 2'b10;
      end
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    check("arready_seen", 32'(arready), 32'd1);
    if (!arready) begin arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    check("arready_low_in_burst", 32'(arready), 32'd0);
    t = 1;
    for (int k = 0; k <= int'(len); k++) begin
      while (!rvalid && t < 300) begin @(negedge clk); t++; end
      check("rvalid_seen", 32'(rvalid), 32'd1);
      if (!rvalid) begin rready = 1'b0; return; end
      if (k == 0) begin
        check("rd_latency", 32'(t), 32'(R_LATENCY + 1));
        first_data = rdata;
      end
      check("rdata", rdata, e_data[k]);
      check("rresp", 32'(rresp), 32'(e_resp[k]));
      check("rlast", 32'(rlast), 32'(k == int'(len)));
      check("rid", 32'(rid), 32'(id));
      if (k == stall_beat) begin
        rready = 1'b0;
        repeat (stall_cycles) begin
          @(negedge clk);
          check("rvalid_hold", 32'(rvalid), 32'd1);
          check("rdata_hold", rdata, e_data[k]);
          check("rlast_hold", 32'(rlast), 32'(k == int'(len)));
        end
      end
      rready = 1'b1;
      @(negedge clk);
      t = 0;
    end
    rready = 1'b0;
    check("rvalid_after_last", 32'(rvalid), 32'd0);
    check("arready_after_last", 32'(arready), 32'd1);
  endtask

  // Write burst from w_data_q/w_strb_q; wlast marks beat nbeats-1
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input int nbeats, output logic [1:0] resp);
    int          last_idx;
    logic        exp_err;
    logic [31:0] a;
    int          t;
    int          idx;
    resp     = 2'b11;
    last_idx = (nbeats - 1 < int'(len)) ? nbeats - 1 : int'(len);
    exp_err  = (nbeats - 1 != int'(len));
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    wvalid = 1'b1; wdata = w_data_q[0]; wstrb = w_strb_q[0]; wlast = (nbeats == 1);
    check("w_blocked_before_aw", 32'(wready), 32'd0);
    t = 0;
    while (!awready && t < 100) begin @(negedge clk); t++; end
    check("awready_seen", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= last_idx; k++) begin
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      wvalid = 1'b1; wdata = w_data_q[k]; wstrb = w_strb_q[k]; wlast = (k == nbeats - 1);
      t = 0;
      while (!wready && t < 100) begin @(negedge clk); t++; end
      check("wready_seen", 32'(wready), 32'd1);
      @(negedge clk);
      a = addr + 32'(k) * (32'd1 << size);
      if (in_range(a)) begin
        idx = int'(a[31:2]);
        for (int b = 0; b < 4; b++) begin
          if (w_strb_q[k][b]) m_mem[idx][8*b +: 8] = w_data_q[k][8*b +: 8];
        end
      end else begin
        exp_err = 1'b1;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); t++; end
    check("bvalid_seen", 32'(bvalid), 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), exp_err ? 32'd2 : 32'd0);
    check("wready_in_resp", 32'(wready), 32'd0);
    resp = bresp;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_after_b", 32'(bvalid), 32'd0);
    check("awready_after_b", 32'(awready), 32'd1);
  endtask

  task automatic load_q(input logic [31:0] d, input logic [3:0] s);
    w_data_q.push_back(d);
    w_strb_q.push_back(s);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          len;
    int          nb;
    int          sb;
    logic [31:0] a;

    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < int'(MEM_WORDS); i++) m_mem[i] = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    reset = 1'b0;

    // Preload mem[i] = i through full-length bursts
    for (int blk = 0; blk < int'(MEM_WORDS) / 256; blk++) begin
      w_data_q.delete(); w_strb_q.delete();
      for (int i = 0; i < 256; i++) load_q(32'(blk * 256 + i), 4'hF);
      axi_write(4'd0, 32'(blk * 1024), 8'd255, 3'd2, 256, r);
    end

    // Scenario 1: 16-beat read with a 5-cycle rready stall
    axi_read(4'd1, 32'h40, 8'd15, 3'd2, 4, 5, d);
    check("t1_first", d, 32'h10);

    // Scenario 2: strobed single-beat write merges bytes
    w_data_q.delete(); w_strb_q.delete();
    load_q(32'h11223344, 4'hF);
    axi_write(4'd1, 32'h100, 8'd0, 3'd2, 1, r);
    w_data_q.delete(); w_strb_q.delete();
    load_q(32'hAABBCCDD, 4'b0101);
    axi_write(4'd1, 32'h100, 8'd0, 3'd2, 1, r);
    check("t2_bresp", 32'(r), 32'd0);
    axi_read(4'd2, 32'h100, 8'd0, 3'd2, -1, 0, d);
    check("t2_word", d, 32'h11BB33DD);

    // Scenario 3: read and write of the same word at the same edge
    w_data_q.delete(); w_strb_q.delete();
    load_q(32'h5, 4'hF);
    fork
      axi_read(4'd3, 32'h100, 8'd0, 3'd2, -1, 0, d);
      axi_write(4'd4, 32'h100, 8'd0, 3'd2, 1, r);
    join
    check("t3_old_data", d, 32'h11BB33DD);
    axi_read(4'd5, 32'h100, 8'd0, 3'd2, -1, 0, d);
    check("t3_new_data", d, 32'h5);

    // Scenario 4: out-of-range read and dropped write
    axi_read(4'd6, 32'h1000, 8'd1, 3'd2, -1, 0, d);
    check("t4_rd_data", d, 32'd0);
    w_data_q.delete(); w_strb_q.delete();
    load_q(32'hDEADBEEF, 4'hF);
    axi_write(4'd7, 32'h1000, 8'd0, 3'd2, 1, r);
    check("t4_bresp", 32'(r), 32'd2);
    axi_read(4'd8, 32'h0, 8'd0, 3'd2, -1, 0, d);
    check("t4_no_alias", d, 32'd0);

    // Address wrap across 2^32: two error beats then words 0 and 1
    axi_read(4'd9, 32'hFFFF_FFF8, 8'd3, 3'd2, -1, 0, d);

    // wlast early and late against awlen
    w_data_q.delete(); w_strb_q.delete();
    for (int i = 0; i < 4; i++) load_q(32'hC0DE_0000 + 32'(i), 4'hF);
    axi_write(4'd10, 32'h200, 8'd3, 3'd2, 2, r);
    check("early_wlast_bresp", 32'(r), 32'd2);
    axi_write(4'd11, 32'h300, 8'd1, 3'd2, 4, r);
    check("late_wlast_bresp", 32'(r), 32'd2);

    // Reset mid-burst abandons the read
    @(negedge clk);
    araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arid = 4'd12; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_arready", 32'(arready), 32'd1);
    reset = 1'b0; rready = 1'b0;

    // Random bursts against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) a = 32'(MEM_WORDS - 4 + $urandom_range(0, 7)) * 4;
      else a = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
      a   = a + 32'($urandom_range(0, 3));
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        sb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len)) : -1;
        axi_read(4'($urandom), a, 8'(len), 3'($urandom_range(0, 2)), sb,
                 int'($urandom_range(1, 3)), d);
      end else begin
        nb = len + 1;
        if ($urandom_range(0, 3) == 0) nb = int'($urandom_range(1, len + 2));
        w_data_q.delete(); w_strb_q.delete();
        for (int i = 0; i < nb; i++) load_q($urandom, 4'($urandom));
        axi_write(4'($urandom), a, 8'(len), 3'($urandom_range(0, 2)), nb, r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name:
axi_sram_slave

Overview:
AXI responder (slave) backed by on-chip word RAM; the memory-side end of the cache-to-AXI bridge, used as the simulation and bring-up target for the I/D cache refill and writeback paths. Serves INCR read/write bursts (arlen/awlen up to 255, 32-bit data), echoes IDs, returns OKAY or SLVERR. lock/cache/prot/burst/wid inputs are not ported; every burst is treated as INCR.

Parameters:
MEM_WORDS, 16384, RAM depth in 32-bit words; byte range 0 .. 4*MEM_WORDS-1.
R_LATENCY, 1, idle cycles between AR handshake and first rvalid (0 = rvalid on the cycle after the handshake).

Ports:
clk input 1 clock
reset input 1 synchronous, active-high
arid input 4 read ID
araddr input 32 read byte address
arlen input 8 read beats minus 1
arsize input 3 read beat size (log2 bytes)
arvalid input 1 AR valid
arready output 1 AR ready
rid output 4 echoed arid
rdata output 32 read data
rresp output 2 read response
rlast output 1 last read beat
rvalid output 1 R valid
rready input 1 R ready
awid input 4 write ID
awaddr input 32 write byte address
awlen input 8 write beats minus 1
awsize input 3 write beat size
awvalid input 1 AW valid
awready output 1 AW ready
wdata input 32 write data
wstrb input 4 byte enables
wlast input 1 last write beat
wvalid input 1 W valid
wready output 1 W ready
bid output 4 echoed awid
bresp output 2 write response
bvalid output 1 B valid
bready input 1 B ready

Behaviour:
- Reset values: arready=1, awready=1. All other outputs are 0: wready, rvalid, rlast, rid, rdata, rresp, bvalid, bid, bresp. RAM contents are not cleared. Reset mid-burst abandons the burst; beats already written stay in RAM.
- Read FSM RD_IDLE -> RD_WAIT -> RD_BEAT:
  - AR handshake latches id, addr, len and size; arready=0 from the next cycle.
  - RD_WAIT counts R_LATENCY cycles, then the first beat is presented.
  - On each rvalid&&rready: addr += (1<<size), modulo 2^32. The next beat is presented the following cycle (1 beat/cycle).
  - rlast=1 exactly on beat len.
  - After the last handshake: rvalid=0 and arready=1 on the next cycle.
  - While rvalid&&!rready, rdata, rresp, rlast and rid hold stable.
- rdata is always the full word mem[addr[31:2]], whatever the size. It is sampled at the edge that loads the beat.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP:
  - WR_IDLE: awready=1, wready=0. W beats are never accepted before AW.
  - WR_DATA: wready=1. Each wvalid&&wready writes the bytes enabled by wstrb into mem[addr[31:2]], then addr += (1<<size).
  - The burst ends on wlast or on beat awlen, whichever comes first. A mismatch between them sets bresp SLVERR.
  - WR_RESP: bvalid=1, bid=awid, held until bready. awready=1 on the cycle after the B handshake.
- Range check, per beat: word index >= MEM_WORDS gives SLVERR (2'b10).
  - Read beat: rdata=0.
  - Write beat: dropped. bresp is sticky SLVERR for the burst.
  - Otherwise the response is OKAY (2'b00).
- Read and write channels run concurrently. When both touch the same word at the same edge, the write lands and the read sample returns the pre-write data.

Optional Feature:
AXI_SLV_STALL_EN: a free-running 2-bit counter (reset 0) inserts backpressure on every cycle where counter==3. On those cycles wready=0, and no new read beat is presented. A rvalid that is already asserted is never withdrawn. Without the macro there is no backpressure beyond the FSMs.

Decomposition:
- Package axi_sram_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, ID width 4, read/write FSM state encodings.
- One sub-module, axi_sram_mem: byte-strobe RAM with 1 write port and 1 read port.

Test Plan:
1. Preload mem[i]=i. Read id=1, araddr 0x40, arlen 15, arsize 2, with rready low for 5 cycles at beat 4 -> 16 beats 0x10..0x1F, rid=1, rresp 0, rlast only on beat 16, data stable through the stall.
2. mem[0x40]=0x11223344. Write id=1, awaddr 0x100, one beat 0xAABBCCDD, wstrb 4'b0101 -> word 0x11BB33DD, bid=1, bresp 0.
3. Read 0x100 and write 0x100 (data 0x5, wstrb 4'hF) hitting the same edge -> rdata returns the old 0x11BB33DD, later read returns 0x5.
4. MEM_WORDS=1024. Read 0x1000, arlen 1 -> 2 beats, rdata 0, rresp 2'b10. Write 0x1000 -> bresp 2'b10, RAM unchanged.
